// File: rtl/alu_cmd_ctrl.sv
// Command front-end for the 12-bit combinational ALU: accepts a command, holds the
// ALU inputs for a settle time, captures Z/flags and hands them out over valid/ready.
module alu_cmd_ctrl #(
  parameter int unsigned W      = 12,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic             cmd_chain,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_op,
  input  logic [W-1:0]     alu_z,
  input  logic             alu_carry,
  input  logic             alu_sign,
  input  logic             alu_ov,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_z,
  output logic             res_carry,
  output logic             res_sign,
  output logic             res_ov,
  output logic             ov_sticky,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [SW-1:0] settle_cnt, settle_cnt_next;
  logic [W-1:0]  acc;
  logic          load_cmd, do_capture, do_accept;

  // State and settle counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
    end
  end

  // Next-state logic and datapath strobes
  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    load_cmd        = 1'b0;
    do_capture      = 1'b0;
    do_accept       = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          load_cmd        = 1'b1;
          settle_cnt_next = SW'(SETTLE - 1);
          state_next      = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_cnt == '0) state_next = CAPTURE;
        else                  settle_cnt_next = settle_cnt - SW'(1);
      end
      CAPTURE: begin
        do_capture = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          do_accept  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered handshakes, operand latch, result capture and bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      res_z     <= '0;
      res_carry <= 1'b0;
      res_sign  <= 1'b0;
      res_ov    <= 1'b0;
      acc       <= '0;
      ov_sticky <= 1'b0;
      op_count  <= '0;
    end else begin
      cmd_ready <= (state_next == IDLE);
      res_valid <= (state_next == HOLD);
      if (load_cmd) begin
        alu_op <= cmd_op;
        alu_b  <= cmd_b;
        alu_a  <= cmd_chain ? acc : cmd_a;
      end
      if (do_capture) begin
        res_z     <= alu_z;
        res_carry <= alu_carry;
        res_sign  <= alu_sign;
        res_ov    <= alu_ov;
        acc       <= alu_z;
      end
      if (do_accept) op_count <= op_count + CNT_W'(1);
      // A delivered overflow wins over a simultaneous clear
      if (do_accept && res_ov) ov_sticky <= 1'b1;
      else if (clr_sticky)     ov_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: two instances (SETTLE=1 and SETTLE=4) share stimulus and
// are checked every cycle against a transaction-level model plus literal expectations.
module tb_alu_cmd_ctrl;

  localparam int unsigned W = 12;
  localparam int unsigned CNT_W = 8;

  logic clk, rst;
  logic cmd_valid, cmd_chain, res_ready, clr_sticky;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_a, cmd_b;

  logic             cmd_ready [2];
  logic             res_valid [2];
  logic [W-1:0]     alu_a     [2];
  logic [W-1:0]     alu_b     [2];
  logic [2:0]       alu_op    [2];
  logic [W-1:0]     alu_z     [2];
  logic             alu_carry [2];
  logic             alu_sign  [2];
  logic             alu_ov    [2];
  logic [W-1:0]     res_z     [2];
  logic             res_carry [2];
  logic             res_sign  [2];
  logic             res_ov    [2];
  logic             ov_sticky [2];
  logic [CNT_W-1:0] op_count  [2];

  int errors = 0;
  int checks = 0;

  // Reference ALU: returns {carry, sign, ov, z}
  function automatic logic [W+2:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    logic [W:0]   sum;
    logic [W-1:0] z;
    logic         c, v;
    sum = '0;
    z   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      3'd0: begin
        z = a[W-1] ? (W'(0) - a) : a;
        v = (a == {1'b1, {(W-1){1'b0}}});
      end
      3'd1: begin
        z = {b[W-2:0], 1'b0};
        c = b[W-1];
        v = b[W-1] ^ b[W-2];
      end
      3'd2: z = a & b;
      3'd3: z = a | b;
      3'd4: z = a ^ b;
      3'd5: z = ~a;
      3'd6: begin
        sum = {1'b0, a} + {1'b0, b};
        z   = sum[W-1:0];
        c   = sum[W];
        v   = (a[W-1] == b[W-1]) && (z[W-1] != a[W-1]);
      end
      default: begin
        z = a - b;
        c = (a < b);
        v = (a[W-1] != b[W-1]) && (z[W-1] != a[W-1]);
      end
    endcase
    return {c, z[W-1], v, z};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_cmd_ctrl #(.W(W), .SETTLE(g == 0 ? 1 : 4), .CNT_W(CNT_W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready[g]),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_chain (cmd_chain),
      .alu_a     (alu_a[g]),
      .alu_b     (alu_b[g]),
      .alu_op    (alu_op[g]),
      .alu_z     (alu_z[g]),
      .alu_carry (alu_carry[g]),
      .alu_sign  (alu_sign[g]),
      .alu_ov    (alu_ov[g]),
      .res_valid (res_valid[g]),
      .res_ready (res_ready),
      .res_z     (res_z[g]),
      .res_carry (res_carry[g]),
      .res_sign  (res_sign[g]),
      .res_ov    (res_ov[g]),
      .ov_sticky (ov_sticky[g]),
      .clr_sticky(clr_sticky),
      .op_count  (op_count[g])
    );
    assign {alu_carry[g], alu_sign[g], alu_ov[g], alu_z[g]} = alu_f(alu_a[g], alu_b[g], alu_op[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: a command is in flight from acceptance until its result
  // is taken; the result appears SETTLE+1 edges after acceptance.
  bit               started = 0;
  int               cyc = 0;
  bit               m_busy [2];
  bit               m_resv [2];
  int               m_tacc [2];
  logic [W-1:0]     m_a [2], m_b [2], m_acc [2], m_z [2];
  logic [2:0]       m_op [2];
  logic             m_c [2], m_s [2], m_v [2], m_st [2];
  logic [CNT_W-1:0] m_cnt [2];

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int  s;
      bit  taken;
      s = (i == 0) ? 1 : 4;
      if (rst) begin
        started   = 1;
        m_busy[i] = 0;
        m_resv[i] = 0;
        m_a[i] = '0; m_b[i] = '0; m_op[i] = '0; m_acc[i] = '0; m_z[i] = '0;
        m_c[i] = 0; m_s[i] = 0; m_v[i] = 0; m_st[i] = 0; m_cnt[i] = '0;
      end else begin
        taken = m_resv[i] && res_ready;
        if (!m_busy[i]) begin
          if (cmd_valid) begin
            m_busy[i] = 1;
            m_tacc[i] = cyc;
            m_a[i]    = cmd_chain ? m_acc[i] : cmd_a;
            m_b[i]    = cmd_b;
            m_op[i]   = cmd_op;
          end
        end else if (!m_resv[i]) begin
          if (cyc == m_tacc[i] + s + 1) begin
            {m_c[i], m_s[i], m_v[i], m_z[i]} = alu_f(m_a[i], m_b[i], m_op[i]);
            m_acc[i]  = m_z[i];
            m_resv[i] = 1;
          end
        end else if (taken) begin
          m_resv[i] = 0;
          m_busy[i] = 0;
          m_cnt[i]  = m_cnt[i] + CNT_W'(1);
        end
        if (taken && m_v[i]) m_st[i] = 1;
        else if (clr_sticky) m_st[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cmd_ready[%0d]", i), 32'(cmd_ready[i]), 32'(!m_busy[i]));
        chk($sformatf("res_valid[%0d]", i), 32'(res_valid[i]), 32'(m_resv[i]));
        chk($sformatf("alu_a[%0d]", i),     32'(alu_a[i]),     32'(m_a[i]));
        chk($sformatf("alu_b[%0d]", i),     32'(alu_b[i]),     32'(m_b[i]));
        chk($sformatf("alu_op[%0d]", i),    32'(alu_op[i]),    32'(m_op[i]));
        chk($sformatf("res_z[%0d]", i),     32'(res_z[i]),     32'(m_z[i]));
        chk($sformatf("res_flags[%0d]", i), 32'({res_carry[i], res_sign[i], res_ov[i]}),
            32'({m_c[i], m_s[i], m_v[i]}));
        chk($sformatf("ov_sticky[%0d]", i), 32'(ov_sticky[i]), 32'(m_st[i]));
        chk($sformatf("op_count[%0d]", i),  32'(op_count[i]),  32'(m_cnt[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic chain);
    int n = 0;
    while (!(cmd_ready[0] && cmd_ready[1]) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("send_ready_timeout", 32'(n), 32'(0));
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_chain = chain;
    step();
    cmd_valid = 1'b0;
    cmd_chain = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!(res_valid[0] && res_valid[1]) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("res_valid_timeout", 32'(n), 32'(0));
  endtask

  task automatic get(input logic clr);
    wait_valid();
    res_ready  = 1'b1;
    clr_sticky = clr;
    step();
    res_ready  = 1'b0;
    clr_sticky = 1'b0;
  endtask

  initial begin
    logic [W-1:0]     snap_z;
    logic [CNT_W-1:0] snap_cnt;
    logic [2:0]       sweep_op [5];
    sweep_op = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

    rst = 1'b1; cmd_valid = 1'b0; cmd_chain = 1'b0; res_ready = 1'b0; clr_sticky = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_cmd_ready", 32'(cmd_ready[0]), 32'(1));
    chk("reset_res_valid", 32'(res_valid[0]), 32'(0));
    chk("reset_op_count",  32'(op_count[0]),  32'(0));
    chk("reset_sticky",    32'(ov_sticky[0]), 32'(0));

    // Signed overflow on add, and result latency with SETTLE=1
    send(3'd6, 12'h7FF, 12'h001, 1'b0);
    chk("lat_edge0", 32'(res_valid[0]), 32'(0));
    step();
    chk("lat_edge1", 32'(res_valid[0]), 32'(0));
    step();
    chk("lat_edge2", 32'(res_valid[0]), 32'(1));
    chk("add_z",     32'(res_z[0]), 32'(12'h800));
    chk("add_flags", 32'({res_carry[0], res_sign[0], res_ov[0]}), 32'(3'b011));
    get(1'b0);
    chk("add_sticky", 32'(ov_sticky[0]), 32'(1));
    chk("add_count",  32'(op_count[0]),  32'(1));

    send(3'd7, 12'h000, 12'h001, 1'b0);
    wait_valid();
    chk("sub_z",     32'(res_z[0]), 32'(12'hFFF));
    chk("sub_flags", 32'({res_carry[0], res_sign[0], res_ov[0]}), 32'(3'b110));
    get(1'b0);

    send(3'd0, 12'h800, 12'h000, 1'b0);
    wait_valid();
    chk("abs_z",  32'(res_z[0]),  32'(12'h800));
    chk("abs_ov", 32'(res_ov[0]), 32'(1));
    get(1'b0);

    for (int k = 0; k < 5; k++) begin
      send(sweep_op[k], 12'hA5C, 12'h6F3, 1'b0);
      get(1'b0);
    end

    // Accumulator chaining ignores cmd_a
    send(3'd6, 12'h005, 12'h003, 1'b0);
    wait_valid();
    chk("chain_first_z", 32'(res_z[0]), 32'(12'h008));
    get(1'b0);
    send(3'd6, 12'h123, 12'h002, 1'b1);
    chk("chain_alu_a", 32'(alu_a[0]), 32'(12'h008));
    wait_valid();
    chk("chain_z", 32'(res_z[0]), 32'(12'h00A));
    get(1'b0);

    // Backpressure with a stray command during HOLD
    send(3'd6, 12'h100, 12'h0F0, 1'b0);
    wait_valid();
    snap_z   = res_z[0];
    snap_cnt = op_count[0];
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 12'h0FF; cmd_b = 12'hF00;
      end
      step();
      cmd_valid = 1'b0;
      chk("bp_cmd_ready", 32'(cmd_ready[0]), 32'(0));
      chk("bp_res_z",     32'(res_z[0]),     32'(snap_z));
    end
    get(1'b0);
    chk("bp_count", 32'(op_count[0]), 32'(snap_cnt + CNT_W'(1)));
    repeat (3) step();
    chk("bp_no_stray", 32'({cmd_ready[0], res_valid[0]}), 32'(2'b10));

    // Reset while the SETTLE=4 instance is in DRIVE
    send(3'd6, 12'h001, 12'h001, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ready", 32'(cmd_ready[1]), 32'(1));
    chk("mid_rst_valid", 32'(res_valid[1]), 32'(0));
    chk("mid_rst_count", 32'(op_count[1]),  32'(0));
    repeat (10) step();
    chk("mid_rst_no_res", 32'(res_valid[1]), 32'(0));

    // 256 deliveries wrap the counter; clear coinciding with an OV delivery keeps sticky
    for (int n = 0; n < 255; n++) begin
      send(3'd6, W'(n), 12'h001, 1'b0);
      get(1'b0);
    end
    chk("wrap_pre_count",  32'(op_count[0]),  32'(255));
    chk("wrap_pre_sticky", 32'(ov_sticky[0]), 32'(0));
    send(3'd6, 12'h7FF, 12'h001, 1'b0);
    get(1'b1);
    chk("wrap_count0",  32'(op_count[0]),  32'(0));
    chk("wrap_count1",  32'(op_count[1]),  32'(0));
    chk("set_wins0",    32'(ov_sticky[0]), 32'(1));
    chk("set_wins1",    32'(ov_sticky[1]), 32'(1));
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("clr_sticky", 32'(ov_sticky[0]), 32'(0));
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
Sequential command front-end for the team's 12-bit combinational `alu` (ports A, B, OP, Z, CarryOut, Sign, OV).
- Accepts ALU commands over a valid/ready handshake and drives the ALU operand/opcode lines.
- Waits a programmable settle time, registers Z and the flags, and presents them over a result valid/ready handshake.
- Provides accumulator chaining (A operand = previous result), sticky overflow and an operation counter for the lab datapath.

Parameters:
- W, 12, operand/result width; must match the ALU.
- SETTLE, 1, cycles ALU inputs are held before capture; legal range 1..15.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  ALU opcode (0 abs, 1 B<<1, 2 and, 3 or, 4 xor, 5 not A, 6 add, 7 sub).
- cmd_a  in  W  operand A; ignored when cmd_chain=1.
- cmd_b  in  W  operand B.
- cmd_chain  in  1  use accumulator as operand A.
- alu_a  out  W  to ALU A.
- alu_b  out  W  to ALU B.
- alu_op  out  3  to ALU OP.
- alu_z  in  W  from ALU Z.
- alu_carry  in  1  from ALU CarryOut.
- alu_sign  in  1  from ALU Sign.
- alu_ov  in  1  from ALU OV.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts the result.
- res_z  out  W  captured Z.
- res_carry  out  1  captured CarryOut.
- res_sign  out  1  captured Sign.
- res_ov  out  1  captured OV.
- ov_sticky  out  1  OR of res_ov since reset or clear.
- clr_sticky  in  1  clears ov_sticky.
- op_count  out  CNT_W  results delivered, modulo 2^CNT_W.

Behaviour:
- **Reset** (rst=1 at a clock edge, any state, including mid-operation):
  - State goes to IDLE and any in-flight command is discarded.
  - cmd_ready=1, res_valid=0.
  - alu_a, alu_b, alu_op, res_z, res_carry, res_sign, res_ov, accumulator, ov_sticky and op_count all go to 0.
- **State IDLE:**
  - cmd_ready=1.
  - On cmd_valid=1, on the same edge:
    - Latch alu_op=cmd_op and alu_b=cmd_b.
    - Latch alu_a = accumulator if cmd_chain=1, else cmd_a.
    - Load settle counter = SETTLE-1, then go to DRIVE.
- **State DRIVE:**
  - cmd_ready=0.
  - alu_a, alu_b and alu_op are held stable.
  - The counter decrements each cycle; when it is 0, go to CAPTURE.
- **State CAPTURE** (exactly one cycle):
  - Register alu_z and the flags into the res_* outputs.
  - Load accumulator = alu_z.
  - Set res_valid=1 on the following edge and go to HOLD.
- **Command latency:** with SETTLE=1, cmd accepted at edge N gives res_valid=1 after edge N+2.
- **State HOLD:**
  - res_valid=1; res_* and alu_* are stable until accepted.
  - On res_valid & res_ready:
    - Set res_valid=0.
    - Increment op_count (wraps 2^CNT_W-1 -> 0).
    - Set ov_sticky |= res_ov.
    - Go to IDLE.
  - No new command is accepted in the same cycle, so the minimum issue interval is SETTLE+3 cycles.
- **Backpressure:** res_ready low holds HOLD indefinitely; cmd_ready stays 0.
- **cmd_ready / cmd_valid:** cmd_valid while cmd_ready=0 is ignored and not queued; the source must hold it.
- **clr_sticky:** clears ov_sticky on the next edge. If clr_sticky coincides with a result acceptance where res_ov=1, ov_sticky ends at 1 (set wins).
- **Flag handling:** flags are copied verbatim from the ALU; no recomputation.
- **Accumulator:** updates only in CAPTURE.
  - The accumulator takes the full 12-bit Z even for logic ops.
  - cmd_chain with no prior result uses 0.

Test Plan:
1. Reset, then op=6 A=0x7FF B=0x001 -> res_z=0x800, res_carry=0, res_sign=1, res_ov=1; res_valid rises 2 cycles after acceptance; ov_sticky=1 after res_ready.
2. op=7 A=0x000 B=0x001 -> res_z=0xFFF, res_carry=1, res_sign=1, res_ov=0; op=0 A=0x800 -> res_z=0x800, res_ov=1.
3. Chain: op=6 A=0x005 B=0x003 -> res_z=0x008; then op=6 cmd_chain=1 cmd_a=0x123 B=0x002 -> alu_a=0x008, res_z=0x00A.
4. Backpressure: res_ready=0 for 5 cycles after res_valid -> res_* stable and cmd_ready=0 throughout; a cmd_valid pulse during HOLD is not executed; op_count increments exactly once.
5. Reset asserted during DRIVE with SETTLE=4 -> next cycle cmd_ready=1, res_valid=0, op_count=0, and no result is ever produced for that command.
6. Issue 256 commands with CNT_W=8 -> op_count wraps to 0x00; clr_sticky together with an OV=1 acceptance leaves ov_sticky=1.
